// File: rtl/continuous_monitoring_system_pkg.sv
// Shared constants and types for the continuous monitoring system.
// This includes the performance counter readout sequencer.
package continuous_monitoring_system_pkg;

   localparam int NO_OF_PERFORMANCE_EVENTS            = 8;
   localparam int PERFORMANCE_EVENT_MOD_COUNTER_WIDTH = 8;
   localparam int PERF_READOUT_PERIOD_WIDTH           = 16;
   localparam int PERF_READOUT_DROP_CNT_WIDTH         = 8;

   typedef enum logic [1:0] {
      PERF_RD_IDLE    = 2'd0,
      PERF_RD_CAPTURE = 2'd1,
      PERF_RD_STREAM  = 2'd2
   } perf_rd_state_e;

endpackage

// File: rtl/perf_counter_readout_sequencer_if.sv
// Snapshot stream from the readout sequencer to the trace/packetizer stage.
// The stream carries one counter per beat.
interface perf_counter_readout_sequencer_if #(
   parameter int COUNTER_WIDTH = continuous_monitoring_system_pkg::PERFORMANCE_EVENT_MOD_COUNTER_WIDTH,
   parameter int INDEX_WIDTH   = $clog2(continuous_monitoring_system_pkg::NO_OF_PERFORMANCE_EVENTS)
);

   logic [COUNTER_WIDTH-1:0] out_data;
   logic [INDEX_WIDTH-1:0]   out_index;
   logic                     out_valid;
   logic                     out_ready;
   logic                     out_last;

   modport master (
      output out_data,
      output out_index,
      output out_valid,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_index,
      input  out_valid,
      input  out_last,
      output out_ready
   );

endinterface

// File: rtl/perf_window_timer.sv
// Window timer: counts 0..period-1 and pulses expire in the wrap cycle.
// The timer is held at 0 while disabled or while period is 0.
module perf_window_timer
   import continuous_monitoring_system_pkg::*;
#(
   parameter int PERIOD_WIDTH = PERF_READOUT_PERIOD_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic [PERIOD_WIDTH-1:0] period,
   output logic                    expire
);

   logic [PERIOD_WIDTH-1:0] timer_q;
   logic [PERIOD_WIDTH-1:0] timer_d;

   // >= rather than == so a period shrunk below the running count still wraps
   always_comb begin
      timer_d = '0;
      expire  = 1'b0;
      if (en && (period != '0)) begin
         if (timer_q >= (period - PERIOD_WIDTH'(1))) begin
            expire = 1'b1;
         end else begin
            timer_d = timer_q + PERIOD_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_d;
      end
   end

endmodule

// File: rtl/perf_counter_readout_sequencer.sv
// Snapshots the performance counter array, periodically or on a trigger, and clears the array.
// It then streams the snapshot out one counter per beat.
//
// state   | meaning
// IDLE    | waiting for a trigger or window expiry
// CAPTURE | snapshot loaded and counters_clr high, exactly one cycle
// STREAM  | beats index 0..NO_OF_EVENTS-1 sent over out_if
module perf_counter_readout_sequencer
   import continuous_monitoring_system_pkg::*;
#(
   parameter int NO_OF_EVENTS   = NO_OF_PERFORMANCE_EVENTS,
   parameter int COUNTER_WIDTH  = PERFORMANCE_EVENT_MOD_COUNTER_WIDTH,
   parameter int PERIOD_WIDTH   = PERF_READOUT_PERIOD_WIDTH,
   parameter int DROP_CNT_WIDTH = PERF_READOUT_DROP_CNT_WIDTH
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en,
   input  logic [PERIOD_WIDTH-1:0]   period,
   input  logic                      trigger,
   input  logic [COUNTER_WIDTH-1:0]  counters_in [NO_OF_EVENTS],
   output logic                      counters_clr,
   perf_counter_readout_sequencer_if.master out_if,
   output logic                      busy,
   output logic [DROP_CNT_WIDTH-1:0] dropped
);

   localparam int IDX_W = (NO_OF_EVENTS > 1) ? $clog2(NO_OF_EVENTS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NO_OF_EVENTS - 1);

   localparam logic [1:0] ST_IDLE    = 2'(PERF_RD_IDLE);
   localparam logic [1:0] ST_CAPTURE = 2'(PERF_RD_CAPTURE);
   localparam logic [1:0] ST_STREAM  = 2'(PERF_RD_STREAM);

   logic [1:0]                state_q, state_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic [COUNTER_WIDTH-1:0]  snap_q [NO_OF_EVENTS];
   logic [COUNTER_WIDTH-1:0]  snap_d [NO_OF_EVENTS];
   logic                      clr_q, clr_d;
   logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;
   logic                      expire;
   logic                      req;
   logic                      is_last;

   perf_window_timer #(
      .PERIOD_WIDTH(PERIOD_WIDTH)
   ) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .period (period),
      .expire (expire)
   );

   assign is_last = (state_q == ST_STREAM) && (idx_q == LAST_IDX);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      snap_d  = snap_q;
      clr_d   = 1'b0;
      drop_d  = drop_q;
      // trigger and expiry in the same cycle collapse into one request
      req     = en && (trigger || expire);

      if (req && (state_q != ST_IDLE) && (drop_q != '1)) begin
         drop_d = drop_q + DROP_CNT_WIDTH'(1);
      end

      case (state_q)
         ST_IDLE: begin
            if (req) begin
               state_d = ST_CAPTURE;
               clr_d   = 1'b1;
            end
         end
         ST_CAPTURE: begin
            snap_d  = counters_in;
            idx_d   = '0;
            state_d = ST_STREAM;
         end
         ST_STREAM: begin
            if (out_if.out_ready) begin
               if (is_last) begin
                  idx_d   = '0;
                  state_d = ST_IDLE;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         snap_q  <= '{default: '0};
         clr_q   <= 1'b0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         snap_q  <= snap_d;
         clr_q   <= clr_d;
         drop_q  <= drop_d;
      end
   end

   assign counters_clr     = clr_q;
   assign busy             = (state_q != ST_IDLE);
   assign dropped          = drop_q;
   assign out_if.out_valid = (state_q == ST_STREAM);
   assign out_if.out_index = idx_q;
   assign out_if.out_data  = snap_q[idx_q];
   assign out_if.out_last  = is_last;

endmodule

// File: doc/perf_counter_readout_sequencer.md
Name:
perf_counter_readout_sequencer

Overview:
- Controller for the performance event counter array.
- Takes periodic or manual snapshots of all counters and issues a one-cycle clear to the array in the snapshot cycle.
- Streams the snapshot out, one counter per beat, over a valid/ready interface to the trace/packetizer stage.
- Gives the monitoring system fixed-window event counts with no counter lost or double-counted between windows.

Parameters:
- NO_OF_EVENTS, 8: number of counters in the array.
- COUNTER_WIDTH, 8: width of each counter and of out_data.
- PERIOD_WIDTH, 16: width of the period register and the window timer.
- DROP_CNT_WIDTH, 8: width of the saturating dropped-snapshot counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- en  in  1  enables window timer and trigger acceptance.
- period  in  PERIOD_WIDTH  window length in cycles; 0 = periodic mode off.
- trigger  in  1  manual snapshot request, single-cycle pulse.
- counters_in  in  COUNTER_WIDTH x NO_OF_EVENTS (unpacked array)  live counter values.
- counters_clr  out  1  synchronous clear to the counter array.
- out_data  out  COUNTER_WIDTH  snapshot value of the current counter.
- out_index  out  $clog2(NO_OF_EVENTS)  index of out_data.
- out_valid  out  1  beat valid.
- out_ready  in  1  sink ready.
- out_last  out  1  final beat of the snapshot.
- busy  out  1  high in CAPTURE or STREAM.
- dropped  out  DROP_CNT_WIDTH  requests dropped while busy, saturating.

Behaviour:
- Reset and clock: one clock domain; reset is asynchronous, active-low (rst_n).
- Reset values: state IDLE; timer 0; index 0; snapshot all 0; every output 0.
- States: IDLE, CAPTURE, STREAM.
- Window timer:
  - Counts while en=1 and period!=0, in all states.
  - At timer==period-1 it wraps to 0 and raises an internal request for that cycle.
  - en=0 or period=0 holds the timer at 0.
- Request = trigger OR timer expiry, qualified by en. Simultaneous trigger and expiry count as one request.
- IDLE -> CAPTURE on a request.
- CAPTURE, exactly 1 cycle:
  - snapshot[i] <= counters_in[i] for all i.
  - counters_clr=1 (registered, high only in this cycle).
  - Then -> STREAM with index=0.
- STREAM:
  - out_valid=1; out_data=snapshot[index]; out_index=index; out_last=(index==NO_OF_EVENTS-1).
  - On out_valid&&out_ready, index increments.
  - On the handshake with out_last=1: -> IDLE, out_valid drops the next cycle, index resets to 0.
  - out_data and out_index stay stable while out_valid&&!out_ready.
- Latency: request sampled at edge T -> counters_clr high in cycle T+1 -> first beat valid in T+2.
  - With out_ready held at 1, a snapshot takes NO_OF_EVENTS+1 cycles from CAPTURE to IDLE.
- Requests while busy:
  - Not queued; dropped increments by 1 per request cycle, saturating at all-ones.
  - A request in the same cycle as the final handshake is also dropped.
- en deasserted mid-STREAM: the stream completes normally. en only gates new requests.
- Reset mid-STREAM: immediate return to reset values. A partially sent snapshot is abandoned, with no out_last.
- counters_clr covers the counting window only. The counter array owns whether an event in the clear cycle is kept.

Decomposition:
- continuous_monitoring_system_pkg gains:
  - typedef enum for the state (IDLE/CAPTURE/STREAM).
  - constant PERF_READOUT_PERIOD_WIDTH.
- NO_OF_PERFORMANCE_EVENTS and PERFORMANCE_EVENT_MOD_COUNTER_WIDTH from the package are the parameter values at integration.
- One sub-module, perf_window_timer: period counter with wrap pulse, en/period gating.
- FSM, snapshot register and output mux stay in this module.

Test Plan:
All scenarios use NO_OF_EVENTS=3, COUNTER_WIDTH=8.
1. Reset: rst_n=0 -> all outputs 0 immediately; release -> state IDLE, dropped=0.
2. Manual trigger, counters_in={5,9,2}, out_ready=1 -> counters_clr 1 cycle later; beats (idx,data)=(0,5),(1,9),(2,2); out_last only on idx 2; busy low 5 cycles after trigger.
3. Periodic mode, period=10, en=1, no triggers -> counters_clr every 10 cycles exactly; each snapshot equals counter values of the preceding window.
4. Backpressure: out_ready low for 4 cycles on beat 1 -> out_data/out_index held at (1,9); completes after ready returns; no beat skipped or repeated.
5. Triggers during STREAM: 3 pulses while busy -> dropped=3, no extra CAPTURE. With DROP_CNT_WIDTH=2, 5 pulses -> dropped saturates at 3.
6. Reset mid-stream after beat 0 -> out_valid falls asynchronously; next trigger restarts at idx 0 with fresh capture.
